// File: rtl/fwd_hazard_unit_if.sv
// ID-stage operand/hazard bus between the decode logic (master) and the
// forwarding/hazard unit (slave).
interface fwd_hazard_unit_if #(
    parameter int REG_W  = 5,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 16
);
    logic                    id_valid;
    logic [REG_W-1:0]        id_rd;
    logic                    id_regwrite;
    logic                    id_memread;
    logic [NUM_RD*REG_W-1:0] id_rs;
    logic [NUM_RD-1:0]       id_rs_used;
    logic                    flush;
    logic                    mem_stall;

    logic [2*NUM_RD-1:0]     fwd_sel;
    logic                    stall_id;
    logic                    bubble_ex;
    logic                    ex_valid;
    logic                    mem_valid;
    logic [CNT_W-1:0]        stall_cnt;

    modport master (
        output id_valid, id_rd, id_regwrite, id_memread, id_rs, id_rs_used,
               flush, mem_stall,
        input  fwd_sel, stall_id, bubble_ex, ex_valid, mem_valid, stall_cnt
    );

    modport slave (
        input  id_valid, id_rd, id_regwrite, id_memread, id_rs, id_rs_used,
               flush, mem_stall,
        output fwd_sel, stall_id, bubble_ex, ex_valid, mem_valid, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit for a 5-stage MIPS pipeline.
// Tracks EX/MEM destination records itself and drives ID operand muxes and stalls.
module fwd_hazard_unit #(
    parameter int REG_W  = 5,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    fwd_hazard_unit_if.slave   bus
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } rec_t;

    typedef enum logic [1:0] {
        FWD_RF       = 2'd0,
        FWD_EX_ALU   = 2'd1,
        FWD_MEM_ALU  = 2'd2,
        FWD_MEM_LOAD = 2'd3
    } fwd_e;

    rec_t              ex_q, ex_d;
    rec_t              mem_q, mem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_RD-1:0]   hit_ex;
    logic [NUM_RD-1:0]   hit_mem;
    logic [2*NUM_RD-1:0] fwd_sel;
    logic                lu_any;
    logic                lu;
    logic                bubble;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        hit_ex  = '0;
        hit_mem = '0;
        fwd_sel = '0;
        lu_any  = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            hit_ex[k]  = bus.id_rs_used[k] && ex_q.valid && ex_q.regwrite &&
                         (ex_q.rd == bus.id_rs[k*REG_W +: REG_W]) &&
                         (bus.id_rs[k*REG_W +: REG_W] != '0);
            hit_mem[k] = bus.id_rs_used[k] && mem_q.valid && mem_q.regwrite &&
                         (mem_q.rd == bus.id_rs[k*REG_W +: REG_W]) &&
                         (bus.id_rs[k*REG_W +: REG_W] != '0);
            // A load in EX has no data yet: it falls through to MEM/RF and raises load-use.
            if (hit_ex[k] && !ex_q.memread)       fwd_sel[2*k +: 2] = FWD_EX_ALU;
            else if (hit_mem[k] && mem_q.memread) fwd_sel[2*k +: 2] = FWD_MEM_LOAD;
            else if (hit_mem[k])                  fwd_sel[2*k +: 2] = FWD_MEM_ALU;
            else                                  fwd_sel[2*k +: 2] = FWD_RF;
            lu_any = lu_any | (hit_ex[k] & ex_q.memread);
        end
        lu     = bus.id_valid & ~bus.flush & lu_any;
        bubble = lu & ~bus.mem_stall;
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (!bus.mem_stall) begin
            mem_d = ex_q;
            if (bus.flush || lu || !bus.id_valid) begin
                ex_d = '0;
            end else begin
                ex_d = '{valid: 1'b1, rd: bus.id_rd,
                         regwrite: bus.id_regwrite, memread: bus.id_memread};
            end
        end
        if (bubble && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.fwd_sel   = fwd_sel;
    assign bus.stall_id  = lu | bus.mem_stall;
    assign bus.bubble_ex = bubble;
    assign bus.ex_valid  = ex_q.valid;
    assign bus.mem_valid = mem_q.valid;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: vector table plus freeze, reset and
// counter-saturation sequences (second instance with CNT_W=2).
module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.REG_W(5), .NUM_RD(2), .CNT_W(16)) bus   ();
    fwd_hazard_unit_if #(.REG_W(5), .NUM_RD(2), .CNT_W(2))  bus_s ();

    fwd_hazard_unit #(.REG_W(5), .NUM_RD(2), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fwd_hazard_unit #(.REG_W(5), .NUM_RD(2), .CNT_W(2)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] used;
        logic       fl;
        logic       ms;
        logic [3:0] fwd;
        logic       st;
        logic       bb;
        logic       exv;
        logic       memv;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                         input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                         input logic fl, input logic ms);
        bus.id_valid      = v;   bus_s.id_valid    = v;
        bus.id_rd         = rd;  bus_s.id_rd       = rd;
        bus.id_regwrite   = rw;  bus_s.id_regwrite = rw;
        bus.id_memread    = mr;  bus_s.id_memread  = mr;
        bus.id_rs         = {rs1, rs0};
        bus_s.id_rs       = {rs1, rs0};
        bus.id_rs_used    = used; bus_s.id_rs_used = used;
        bus.flush         = fl;  bus_s.flush       = fl;
        bus.mem_stall     = ms;  bus_s.mem_stall   = ms;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] fwd, input logic st,
                              input logic bb, input logic exv, input logic memv,
                              input logic [15:0] cnt);
        check({tag, ".fwd_sel"},   32'(bus.fwd_sel),   32'(fwd));
        check({tag, ".stall_id"},  32'(bus.stall_id),  32'(st));
        check({tag, ".bubble_ex"}, 32'(bus.bubble_ex), 32'(bb));
        check({tag, ".ex_valid"},  32'(bus.ex_valid),  32'(exv));
        check({tag, ".mem_valid"}, 32'(bus.mem_valid), 32'(memv));
        check({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          v   rd  rw mr rs0 rs1 used fl ms  fwd     st bb exv memv cnt
        vecs[0]  = '{1, 3,  1, 0, 1,  2,  3,   0, 0, 4'b0000, 0, 0, 0, 0, 0}; // add $3
        vecs[1]  = '{1, 4,  1, 0, 3,  0,  3,   0, 0, 4'b0001, 0, 0, 1, 0, 0}; // rs=$3 from EX
        vecs[2]  = '{1, 9,  1, 0, 8,  3,  3,   0, 0, 4'b1000, 0, 0, 1, 1, 0}; // rt=$3 from MEM
        vecs[3]  = '{1, 5,  1, 1, 1,  2,  3,   0, 0, 4'b0000, 0, 0, 1, 1, 0}; // lw $5
        vecs[4]  = '{1, 10, 1, 0, 5,  9,  3,   0, 0, 4'b1000, 1, 1, 1, 1, 0}; // load-use stall
        vecs[5]  = '{1, 10, 1, 0, 5,  9,  3,   0, 0, 4'b0011, 0, 0, 0, 1, 1}; // load data fwd
        vecs[6]  = '{1, 0,  1, 0, 0,  0,  3,   0, 0, 4'b0000, 0, 0, 1, 0, 1}; // writer $0
        vecs[7]  = '{1, 11, 0, 0, 0,  10, 3,   0, 0, 4'b1000, 0, 0, 1, 1, 1}; // rs=$0 suppressed
        vecs[8]  = '{1, 6,  1, 1, 1,  2,  3,   0, 0, 4'b0000, 0, 0, 1, 1, 1}; // lw $6
        vecs[9]  = '{1, 12, 1, 0, 2,  6,  1,   0, 0, 4'b0000, 0, 0, 1, 1, 1}; // rt=$6 unused
        vecs[10] = '{1, 7,  1, 0, 1,  2,  3,   0, 0, 4'b0000, 0, 0, 1, 1, 1}; // add $7
        vecs[11] = '{1, 7,  1, 0, 2,  3,  3,   0, 0, 4'b0000, 0, 0, 1, 1, 1}; // add $7 again
        vecs[12] = '{1, 13, 0, 0, 7,  7,  3,   0, 0, 4'b0101, 0, 0, 1, 1, 1}; // EX beats MEM
        vecs[13] = '{1, 8,  1, 1, 1,  2,  3,   0, 0, 4'b0000, 0, 0, 1, 1, 1}; // lw $8
        vecs[14] = '{1, 14, 1, 0, 8,  0,  3,   1, 0, 4'b0000, 0, 0, 1, 1, 1}; // flush beats lu
        vecs[15] = '{0, 0,  0, 0, 0,  0,  0,   0, 0, 4'b0000, 0, 0, 0, 1, 1}; // EX bubbled
        vecs[16] = '{0, 0,  0, 0, 0,  0,  0,   0, 0, 4'b0000, 0, 0, 0, 0, 1};

        idle();
        rst = 1'b1;
        #2;
        check_outs("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            next_cycle();
            drive(vecs[i].v, vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].rs0, vecs[i].rs1,
                  vecs[i].used, vecs[i].fl, vecs[i].ms);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].fwd, vecs[i].st, vecs[i].bb,
                       vecs[i].exv, vecs[i].memv, vecs[i].cnt);
        end

        // Freeze: records and counter hold while mem_stall is high, even with load-use pending.
        next_cycle();
        drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd5, 1'b1, 1'b1, 5'd1, 5'd2, 2'b11, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd5, 5'd3, 2'b11, 1'b0, 1'b1);
            #1;
            check_outs($sformatf("freeze%0d", c), 4'b1000, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1);
        end
        next_cycle();
        drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd5, 5'd3, 2'b11, 1'b0, 1'b0);
        #1;
        check_outs("unfreeze", 4'b1000, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1);
        next_cycle();
        #1;
        check_outs("after_stall", 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2);

        // Asynchronous reset in the middle of a load-use stall.
        next_cycle();
        drive(1'b1, 5'd5, 1'b1, 1'b1, 5'd1, 5'd2, 2'b11, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd5, 5'd0, 2'b11, 1'b0, 1'b0);
        #1;
        check("pre_rst.stall_id", 32'(bus.stall_id), 32'd1);
        rst = 1'b1;
        #1;
        check_outs("mid_rst", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        check("mid_rst.sat_cnt", 32'(bus_s.stall_cnt), 32'd0);
        idle();
        @(negedge clk);
        rst = 1'b0;

        // Five load-use stalls: wide counter reaches 5, 2-bit counter saturates at 3.
        for (int s = 0; s < 5; s++) begin
            next_cycle();
            drive(1'b1, 5'd5, 1'b1, 1'b1, 5'd1, 5'd2, 2'b11, 1'b0, 1'b0);
            next_cycle();
            drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd5, 5'd0, 2'b11, 1'b0, 1'b0);
            #1;
            check($sformatf("sat%0d.bubble_ex", s), 32'(bus.bubble_ex), 32'd1);
            next_cycle();
            #1;
            check($sformatf("sat%0d.cnt16", s), 32'(bus.stall_cnt), 32'(s + 1));
            check($sformatf("sat%0d.cnt2", s), 32'(bus_s.stall_cnt),
                  32'((s + 1 > 3) ? 3 : s + 1));
        end

        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
